// File: rtl/pps_qualifier_pkg.sv
// Shared FSM encoding, register map and period-check helper for the PPS qualifier.
package pps_qualifier_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2
    } pps_state_e;

    localparam logic [1:0] AddrNominal = 2'd0;
    localparam logic [1:0] AddrTol     = 2'd1;
    localparam logic [1:0] AddrPeriod  = 2'd2;
    localparam logic [1:0] AddrStatus  = 2'd3;

    localparam logic [31:0] CountMax = 32'hFFFF_FFFF;
    localparam logic [7:0]  EvtMax   = 8'hFF;

    // |period - nominal| <= tol, widened to 33 bits so neither side can wrap.
    function automatic logic within_tol(input logic [31:0] period,
                                        input logic [31:0] nominal,
                                        input logic [31:0] tol);
        logic signed [32:0] diff;
        logic        [32:0] mag;
        diff = $signed({1'b0, period}) - $signed({1'b0, nominal});
        mag  = diff[32] ? $unsigned(-diff) : $unsigned(diff);
        return mag <= {1'b0, tol};
    endfunction

endpackage

// File: rtl/pps_sync.sv
// Two-flop synchronizer for the raw PPS input with rising-edge detect.
module pps_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_edge
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign o_edge = sync_q & ~prev_q;

endmodule

// File: rtl/pps_qualifier.sv
// Qualifies a raw GPS PPS against a programmable nominal period and tolerance,
// emitting a one-cycle o_pps only once a run of good periods has been seen.
module pps_qualifier
    import pps_qualifier_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY_HZ = 81_250_000,
    parameter int unsigned DEF_TOLERANCE      = 8192,
    parameter int unsigned LOCK_COUNT         = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_gps_pps,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_pps,
    output logic        o_locked
);

    localparam int unsigned    GoodW    = $clog2(LOCK_COUNT) + 1;
    localparam logic [GoodW-1:0] LockLast = GoodW'(LOCK_COUNT - 1);

    logic             pps_edge;
    logic [31:0]      counter_q;
    logic [31:0]      counter_d;
    logic [31:0]      count_inc;
    logic [31:0]      r_nominal;
    logic [31:0]      r_tol;
    logic [31:0]      r_period;
    logic [32:0]      timeout_limit;
    logic             period_good;
    logic             timeout;
    pps_state_e       state_q;
    pps_state_e       state_d;
    logic [GoodW-1:0] good_cnt_q;
    logic [GoodW-1:0] good_cnt_d;
    logic [7:0]       reject_cnt_q;
    logic [7:0]       reject_cnt_d;
    logic [7:0]       miss_cnt_q;
    logic [7:0]       miss_cnt_d;
    logic             reject_inc;
    logic             miss_inc;
    logic             pps_d;
    logic             wr_en;
    logic             cnt_clear;
    logic [31:0]      rd_data;

    pps_sync u_pps_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_gps_pps),
        .o_edge    (pps_edge)
    );

    // Interval measurement: count_inc doubles as the period seen on an edge.
    always_comb begin
        count_inc     = (counter_q == CountMax) ? CountMax : counter_q + 32'd1;
        counter_d     = pps_edge ? 32'd0 : count_inc;
        period_good   = within_tol(count_inc, r_nominal, r_tol);
        timeout_limit = {1'b0, r_nominal} + {1'b0, r_tol};
        timeout       = {1'b0, counter_q} > timeout_limit;
    end

    assign wr_en     = i_wb_stb & i_wb_we;
    assign cnt_clear = wr_en && (i_wb_addr == AddrStatus);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            counter_q <= 32'd0;
            r_period  <= 32'd0;
            r_nominal <= 32'(CLOCK_FREQUENCY_HZ);
            r_tol     <= 32'(DEF_TOLERANCE);
        end else begin
            counter_q <= counter_d;
            if (pps_edge) begin
                r_period <= count_inc;
            end
            if (wr_en && (i_wb_addr == AddrNominal)) begin
                r_nominal <= i_wb_data;
            end
            if (wr_en && (i_wb_addr == AddrTol)) begin
                r_tol <= i_wb_data;
            end
        end
    end

    // An edge is handled before the timeout so a same-cycle edge always wins.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        reject_inc = 1'b0;
        miss_inc   = 1'b0;
        pps_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (pps_edge) begin
                    state_d    = StAcquire;
                    good_cnt_d = '0;
                end
            end
            StAcquire: begin
                if (pps_edge) begin
                    if (period_good) begin
                        if (good_cnt_q == LockLast) begin
                            state_d = StLocked;
                            pps_d   = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end else begin
                        good_cnt_d = '0;
                        reject_inc = 1'b1;
                    end
                end else if (timeout) begin
                    state_d  = StIdle;
                    miss_inc = 1'b1;
                end
            end
            StLocked: begin
                if (pps_edge) begin
                    if (period_good) begin
                        pps_d = 1'b1;
                    end else begin
                        state_d    = StAcquire;
                        good_cnt_d = '0;
                        reject_inc = 1'b1;
                    end
                end else if (timeout) begin
                    state_d  = StIdle;
                    miss_inc = 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                good_cnt_d = '0;
            end
        endcase
    end

    // Event counters saturate; a software clear beats a same-cycle increment.
    always_comb begin
        reject_cnt_d = reject_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (cnt_clear) begin
            reject_cnt_d = 8'd0;
            miss_cnt_d   = 8'd0;
        end else begin
            if (reject_inc && (reject_cnt_q != EvtMax)) begin
                reject_cnt_d = reject_cnt_q + 8'd1;
            end
            if (miss_inc && (miss_cnt_q != EvtMax)) begin
                miss_cnt_d = miss_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            good_cnt_q   <= '0;
            reject_cnt_q <= 8'd0;
            miss_cnt_q   <= 8'd0;
            o_pps        <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            reject_cnt_q <= reject_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            o_pps        <= pps_d;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (i_wb_addr)
            AddrNominal: rd_data = r_nominal;
            AddrTol:     rd_data = r_tol;
            AddrPeriod:  rd_data = r_period;
            default:     rd_data = {state_q, 14'h0, reject_cnt_q, miss_cnt_q};
        endcase
    end

    // Read data is captured only on strobed cycles and held between accesses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'd0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) begin
                o_wb_data <= rd_data;
            end
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_locked   = (state_q == StLocked);

endmodule

// File: tb/tb_pps_qualifier.sv
// Directed bench for pps_qualifier: per-cycle reference model plus literal register checks.
module tb_pps_qualifier;

    localparam int unsigned NOM  = 1000;
    localparam int unsigned TOL  = 10;
    localparam int unsigned LOCK = 4;
    localparam logic [31:0] SKIP = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        gps_pps;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_stall;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        pps_out;
    logic        locked;

    int n_tests = 0;
    int n_fail  = 0;
    int pps_seen = 0;

    pps_qualifier #(
        .CLOCK_FREQUENCY_HZ (NOM),
        .DEF_TOLERANCE      (TOL),
        .LOCK_COUNT         (LOCK)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_gps_pps  (gps_pps),
        .i_wb_stb   (wb_stb),
        .i_wb_we    (wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_wdata),
        .o_wb_stall (wb_stall),
        .o_wb_ack   (wb_ack),
        .o_wb_data  (wb_rdata),
        .o_pps      (pps_out),
        .o_locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the input seen through a 2-cycle delay line, an interval
    // count in plain integers, and a count of good periods since acquisition.
    longint      m_count, m_period, m_nom, m_tol, m_per, m_dev;
    int          m_state, m_good, m_rej, m_miss;
    bit          m_pps, m_ack, m_edge, m_good_per, m_tmo, m_inc_rej, m_inc_miss;
    bit [2:0]    m_hist;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_status();
        logic [1:0] st;
        logic [7:0] rj;
        logic [7:0] ms;
        st = m_state[1:0];
        rj = m_rej[7:0];
        ms = m_miss[7:0];
        return {st, 14'h0, rj, ms};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_period = 0; m_nom = NOM; m_tol = TOL;
            m_state = 0; m_good = 0; m_rej = 0; m_miss = 0;
            m_pps = 0; m_ack = 0; m_hist = 3'b000; m_rdata = 32'd0;
        end else begin
            m_edge     = m_hist[1] && !m_hist[2];
            m_per      = (m_count >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count + 1;
            m_dev      = m_per - m_nom;
            if (m_dev < 0) m_dev = -m_dev;
            m_good_per = (m_dev <= m_tol);
            m_tmo      = (m_count > m_nom + m_tol);
            m_inc_rej  = 0;
            m_inc_miss = 0;
            m_pps      = 0;
            m_ack      = wb_stb;
            if (wb_stb) begin
                case (wb_addr)
                    2'd0: m_rdata = m_nom[31:0];
                    2'd1: m_rdata = m_tol[31:0];
                    2'd2: m_rdata = m_period[31:0];
                    default: m_rdata = m_status();
                endcase
            end
            if (m_edge) begin
                m_period = m_per;
                if (m_state == 0) begin
                    m_state = 1; m_good = 0;
                end else if (m_good_per) begin
                    if (m_state == 2) begin
                        m_pps = 1;
                    end else begin
                        m_good++;
                        if (m_good >= LOCK) begin m_state = 2; m_pps = 1; end
                    end
                end else begin
                    m_state = 1; m_good = 0; m_inc_rej = 1;
                end
            end else if (m_state != 0 && m_tmo) begin
                m_state = 0; m_inc_miss = 1;
            end
            m_count = m_edge ? 0 : m_per;
            if (m_inc_rej && m_rej < 255) m_rej++;
            if (m_inc_miss && m_miss < 255) m_miss++;
            if (wb_stb && wb_we) begin
                if (wb_addr == 2'd0) m_nom = longint'(wb_wdata);
                if (wb_addr == 2'd1) m_tol = longint'(wb_wdata);
                if (wb_addr == 2'd3) begin m_rej = 0; m_miss = 0; end
            end
            m_hist = {m_hist[1:0], gps_pps};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("o_pps", {31'd0, pps_out}, {31'd0, m_pps});
            check("o_locked", {31'd0, locked}, {31'd0, m_state == 2});
            check("o_wb_ack", {31'd0, wb_ack}, {31'd0, m_ack});
            check("o_wb_data", wb_rdata, m_rdata);
            check("o_wb_stall", {31'd0, wb_stall}, 32'd0);
            if (pps_out) pps_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_read(input logic [1:0] addr, output logic [31:0] data);
        wb_stb = 1'b1; wb_we = 1'b0; wb_addr = addr;
        tick();
        wb_stb = 1'b0;
        data = wb_rdata;
    endtask

    task automatic wb_write(input logic [1:0] addr, input logic [31:0] data);
        wb_stb = 1'b1; wb_we = 1'b1; wb_addr = addr; wb_wdata = data;
        tick();
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        wb_read(addr, d);
        check(name, d, exp);
    endtask

    // One PPS rise, then n cycles until the next rise would start.
    task automatic gap(input int n);
        gps_pps = 1'b1;
        repeat (5) tick();
        gps_pps = 1'b0;
        repeat (n - 5) tick();
    endtask

    // Same as gap, but reads status and period a few cycles after the rise.
    task automatic gap_chk(input int n, input logic [31:0] exp_st, input logic [31:0] exp_per,
                           input string name);
        logic [31:0] d;
        gps_pps = 1'b1;
        repeat (5) tick();
        gps_pps = 1'b0;
        wb_read(2'd3, d);
        check({name, "_status"}, d, exp_st);
        wb_read(2'd2, d);
        if (exp_per != SKIP) check({name, "_period"}, d, exp_per);
        repeat (n - 7) tick();
    endtask

    initial begin
        rst_n = 1'b0; gps_pps = 1'b0;
        wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_wdata = 32'd0;
        repeat (3) tick();
        check("rst_pps", {31'd0, pps_out}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_data", wb_rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        read_check(2'd0, 32'd1000, "nominal_default");
        read_check(2'd1, 32'd10, "tol_default");
        read_check(2'd2, 32'd0, "period_reset");
        read_check(2'd3, 32'd0, "status_reset");
        repeat (20) tick();

        // Acquire then lock on the fourth good period.
        repeat (4) gap(1000);
        check("not_yet_locked", {31'd0, locked}, 32'd0);
        gap_chk(1000, 32'h8000_0000, 32'd1000, "locked");
        check("locked_flag", {31'd0, locked}, 32'd1);
        check("first_pulse", pps_seen, 1);

        // Early edge at 950 drops to ACQUIRE, then relock.
        repeat (3) gap(1000);
        gap(950);
        gap_chk(1000, 32'h4000_0100, 32'd950, "early_edge");
        repeat (3) gap(1000);
        gap_chk(1000, 32'h8000_0100, 32'd1000, "relock");
        check("pulses_relock", pps_seen, 6);

        // Tolerance boundaries: 990/1010 accepted, 1011/989 rejected.
        gap(990);
        gap(1010);
        gap(1011);
        gap_chk(989, 32'h4000_0200, 32'd1011, "reject_1011");
        gap_chk(1000, 32'h4000_0300, 32'd989, "reject_989");
        check("pulses_bounds", pps_seen, 9);

        // Relock, then PPS stops.
        repeat (3) gap(1000);
        gap_chk(1000, 32'h8000_0300, 32'd1000, "relock2");
        repeat (1100) tick();
        read_check(2'd3, 32'h0000_0301, "timeout_status");
        check("timeout_unlocked", {31'd0, locked}, 32'd0);
        check("pulses_timeout", pps_seen, 10);

        // Lock, reprogram, then reset mid-period.
        repeat (4) gap(1000);
        gap(500);
        check("locked_again", {31'd0, locked}, 32'd1);
        wb_write(2'd0, 32'd1234);
        wb_write(2'd1, 32'd55);
        read_check(2'd0, 32'd1234, "nominal_rw");
        read_check(2'd1, 32'd55, "tol_rw");
        rst_n = 1'b0;
        #1;
        check("midrst_pps", {31'd0, pps_out}, 32'd0);
        check("midrst_locked", {31'd0, locked}, 32'd0);
        check("midrst_ack", {31'd0, wb_ack}, 32'd0);
        check("midrst_data", wb_rdata, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        read_check(2'd0, 32'd1000, "nominal_after_rst");
        read_check(2'd1, 32'd10, "tol_after_rst");
        read_check(2'd2, 32'd0, "period_after_rst");
        read_check(2'd3, 32'd0, "status_after_rst");
        repeat (30) tick();
        gap_chk(1000, 32'h4000_0000, SKIP, "first_after_rst");

        // 300 bad edges saturate reject_cnt; clear through addr3.
        repeat (300) gap(20);
        gap_chk(20, 32'h4000_FF00, 32'd20, "reject_sat");
        wb_write(2'd3, 32'd0);
        read_check(2'd3, 32'h4000_0000, "status_cleared");
        read_check(2'd2, 32'd20, "period_last");
        repeat (1100) tick();
        read_check(2'd3, 32'h0000_0001, "final_timeout");
        check("pulses_final", pps_seen, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
